// File: rtl/key_seq_decoder.sv
// Address-nibble unlock sequencer with a Galois LFSR keystream on SDRD.
// Optional macro KEYSEQ_LOCKOUT_EN adds failure counting and a timed lockout.
module key_seq_decoder #(
    parameter int KEY_LEN = 4,
    parameter int NIB_W = 4,
    parameter logic [KEY_LEN*NIB_W-1:0] KEY = 16'hA5C3,
    parameter int LFSR_W = 8,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 8'hE1,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8,
    parameter int MAX_FAIL = 3,
    parameter int LOCKOUT_LEN = 16,
    localparam int SW = $clog2(KEY_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             acc_stb,
    input  logic             SSER,
    input  logic             BA13,
    input  logic             BA12,
    input  logic [NIB_W-1:0] BA_KEY,
    input  logic             BR_W,
    output logic             SDRD,
    output logic             sdrd_oe,
    output logic             unlocked,
    output logic [SW-1:0]    step
);

    // state      | meaning
    // ST_LOCKED  | idle, waiting for key[0]
    // ST_SEQ     | part of the key matched, step holds progress
    // ST_OPEN    | unlocked, reads return keystream bits
    // ST_LOCKOUT | too many failures, all accesses ignored until timer expires
    typedef enum logic [1:0] {
        ST_LOCKED  = 2'd0,
        ST_SEQ     = 2'd1,
        ST_OPEN    = 2'd2
`ifdef KEYSEQ_LOCKOUT_EN
        ,
        ST_LOCKOUT = 2'd3
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       step_q, step_d;
    logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
    logic                unlocked_q;
    logic [NIB_W-1:0]    key_nib;
    logic                win, qrd, qwr;

`ifdef KEYSEQ_LOCKOUT_EN
    localparam int FW = $clog2(MAX_FAIL + 1);
    localparam int LW = $clog2(LOCKOUT_LEN + 1);
    logic [FW-1:0] fail_q, fail_d;
    logic [LW-1:0] lock_q, lock_d;
`else
    logic [31:0] unused_cfg;
    assign unused_cfg = MAX_FAIL ^ LOCKOUT_LEN;
`endif

    assign win = acc_stb & ~SSER & ~BA13 & BA12;
    assign qrd = win & BR_W;
    assign qwr = win & ~BR_W;

    assign sdrd_oe  = (state_q == ST_OPEN) & qrd;
    assign SDRD     = sdrd_oe & lfsr_q[0];
    assign unlocked = unlocked_q;
    assign step     = step_q;

    always_comb begin
        key_nib = '0;
        for (int i = 0; i < KEY_LEN; i++) begin
            if (step_q == SW'(i)) key_nib = KEY[i*NIB_W +: NIB_W];
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        lfsr_d  = lfsr_q;
`ifdef KEYSEQ_LOCKOUT_EN
        fail_d  = fail_q;
        lock_d  = lock_q;
`endif
        unique case (state_q)
            ST_LOCKED, ST_SEQ: begin
                if (qwr) begin
                    state_d = ST_LOCKED;
                    step_d  = '0;
                end else if (qrd) begin
                    if (BA_KEY == key_nib) begin
                        if (step_q == SW'(KEY_LEN - 1)) begin
                            state_d = ST_OPEN;
                            step_d  = SW'(KEY_LEN);
                            lfsr_d  = LFSR_SEED;
`ifdef KEYSEQ_LOCKOUT_EN
                            fail_d  = '0;
`endif
                        end else begin
                            state_d = ST_SEQ;
                            step_d  = step_q + 1'b1;
                        end
                    end else begin
                        // no re-arm: a mismatch always restarts from key[0] next access
                        state_d = ST_LOCKED;
                        step_d  = '0;
`ifdef KEYSEQ_LOCKOUT_EN
                        if (fail_q >= FW'(MAX_FAIL - 1)) begin
                            fail_d  = FW'(MAX_FAIL);
                            state_d = ST_LOCKOUT;
                            lock_d  = LW'(LOCKOUT_LEN);
                        end else begin
                            fail_d = fail_q + 1'b1;
                        end
`endif
                    end
                end
            end
            ST_OPEN: begin
                if (qwr) begin
                    state_d = ST_LOCKED;
                    step_d  = '0;
                end else if (qrd) begin
                    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : '0);
                end
            end
`ifdef KEYSEQ_LOCKOUT_EN
            ST_LOCKOUT: begin
                // leave on the edge where the timer reaches zero
                if (lock_q <= LW'(1)) begin
                    lock_d  = '0;
                    state_d = ST_LOCKED;
                    fail_d  = '0;
                end else begin
                    lock_d = lock_q - 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_LOCKED;
                step_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_LOCKED;
            step_q     <= '0;
            lfsr_q     <= LFSR_SEED;
            unlocked_q <= 1'b0;
`ifdef KEYSEQ_LOCKOUT_EN
            fail_q     <= '0;
            lock_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            lfsr_q     <= lfsr_d;
            unlocked_q <= (state_d == ST_OPEN);
`ifdef KEYSEQ_LOCKOUT_EN
            fail_q     <= fail_d;
            lock_q     <= lock_d;
`endif
        end
    end

endmodule

// File: doc/key_seq_decoder.md
KEY_SEQ_DECODER -- requirements
Module: key_seq_decoder

Interface
REQ-001 Parameter KEY_LEN, 4, number of address-nibble steps in the unlock sequence (1..8).
REQ-002 Parameter NIB_W, 4, width of the key nibble taken from the address bus.
REQ-003 Parameter KEY, 16'hA5C3, packed key; step i compares against KEY[i*NIB_W +: NIB_W], so step 0 uses the low nibble.
REQ-004 Parameter LFSR_W, 8, keystream register width.
REQ-005 Parameter LFSR_SEED, 8'hE1, keystream load value, nonzero.
REQ-006 Parameter LFSR_TAPS, 8'hB8, Galois feedback mask.
REQ-007 Parameter MAX_FAIL, 3, consecutive failed sequences that trigger lockout.
REQ-008 Parameter LOCKOUT_LEN, 16, lockout duration in clk cycles.
REQ-009 clk  in  1  single clock; all state updates on its rising edge.
REQ-010 rst_n  in  1  reset, asynchronous, active-low.
REQ-011 acc_stb  in  1  one-cycle pulse marking a valid bus access.
REQ-012 SSER  in  1  device select, active-low.
REQ-013 BA13, BA12  in  1 each  window decode bits.
REQ-014 BA_KEY  in  NIB_W  address key nibble (BA7..BA4 at default width).
REQ-015 BR_W  in  1  1 = read, 0 = write.
REQ-016 SDRD  out  1  keystream data bit; 0 whenever sdrd_oe is 0.
REQ-017 sdrd_oe  out  1  output enable for SDRD onto the data bus.
REQ-018 unlocked  out  1  high while the state is OPEN.
REQ-019 step  out  ceil(log2(KEY_LEN+1))  count of matched key steps.

Function
REQ-020 Window hit win = acc_stb & ~SSER & ~BA13 & BA12; qrd = win & BR_W; qwr = win & ~BR_W; with no hit, all state holds.
REQ-021 States: LOCKED, SEQ, OPEN, and LOCKOUT (LOCKOUT only with KEYSEQ_LOCKOUT_EN).
REQ-022 LOCKED: qrd with BA_KEY == key[0] goes to SEQ with step=1, or directly to OPEN if KEY_LEN==1; qrd with a mismatch stays LOCKED and counts one failure.
REQ-023 SEQ: qrd with BA_KEY == key[step] increments step; a match at step KEY_LEN-1 goes to OPEN.
REQ-024 SEQ mismatch on qrd goes to LOCKED with step=0 and counts one failure; there is no re-arm on key[0] in the same access.
REQ-025 Entering OPEN loads the LFSR with LFSR_SEED, sets step=KEY_LEN and clears the fail counter.
REQ-026 OPEN: sdrd_oe = qrd (combinational) and SDRD = lfsr[0] in the same cycle; the LFSR advances on the following edge.
REQ-027 LFSR next value = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 0).
REQ-028 qwr in any state except LOCKOUT goes to LOCKED with step=0; it does not count as a failure, and the fail counter is unchanged.
REQ-029 sdrd_oe is 0 in every state other than OPEN; unlocked is registered from the state.
REQ-030 The fail counter saturates at MAX_FAIL.

Reset
REQ-031 While rst_n is low: state=LOCKED, step=0, lfsr=LFSR_SEED, fail and lockout counters=0, SDRD=0, sdrd_oe=0, unlocked=0.
REQ-032 Reset mid-sequence or mid-lockout discards all progress immediately, without waiting for a clock edge.

Configuration
REQ-033 With KEYSEQ_LOCKOUT_EN defined, the failure that brings the fail count to MAX_FAIL enters LOCKOUT and loads the lockout counter with LOCKOUT_LEN.
REQ-034 In LOCKOUT, the lockout counter decrements every clk cycle and all accesses, including qwr, are ignored; at 0 the block goes to LOCKED and clears the fail counter.
REQ-035 Without KEYSEQ_LOCKOUT_EN, no fail counter, lockout counter or LOCKOUT state is built, and a failure simply returns to LOCKED.

Verification
REQ-036 Reads with BA_KEY 3,C,5,A (defaults) -> step goes 1,2,3,4; unlocked=1 the cycle after the 4th read.
REQ-037 Then 5 qrd in OPEN -> SDRD = 1,0,0,0,1 with sdrd_oe high only in the qrd cycles.
REQ-038 Sequence 3,C,7 -> LOCKED, step=0 after the 3rd read; a following 3,C,5,A unlocks.
REQ-039 qwr while OPEN -> LOCKED; re-unlock restarts SDRD at 1 (seed reload).
REQ-040 With macro: 3 bad reads -> LOCKOUT; a correct sequence within 16 cycles is ignored; after 16 cycles a correct sequence unlocks.
REQ-041 rst_n pulsed low after 3,C -> step=0 asynchronously; SSER=1 or BA13=1 accesses never change state.
